// File: rtl/cmp_pkg.sv
// Shared types and default sizing for the iterative magnitude comparator.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   localparam int CMP_WIDTH = 32;
   localparam int CMP_DIGIT = 4;

endpackage

// File: rtl/cmp_digit.sv
// One DIGIT-bit unsigned slice comparison: less-than and equality flags.
module cmp_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq
);

   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/iter_comparator.sv
// Digit-serial signed/unsigned comparator, MSB digit first, with optional early exit
// on the first unequal digit.
module iter_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH      = CMP_WIDTH,
   parameter int DIGIT      = CMP_DIGIT,
   parameter int EARLY_EXIT = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_signed,
   output logic             o_valid,
   output logic             o_less,
   output logic             o_equal,
   output logic             o_greater,
   output logic [1:0]       o_state
);

   localparam int NDIG  = WIDTH / DIGIT;
   localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("iter_comparator: WIDTH (%0d) must be a multiple of DIGIT (%0d)", WIDTH, DIGIT);
      end
   endgenerate

   cmp_state_t       state;
   cmp_state_t       state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sign_mask;
   logic [IDX_W-1:0] idx;
   logic             prev_less;
   logic             prev_equal;
   logic             slice_lt;
   logic             slice_eq;
   logic             cur_less;
   logic             cur_equal;
   logic             finish;

   // Operands shift left each digit so the digit under test is always the top slice.
   cmp_digit #(.DIGIT(DIGIT)) u_digit (
      .a  (a_q[WIDTH-1 -: DIGIT]),
      .b  (b_q[WIDTH-1 -: DIGIT]),
      .lt (slice_lt),
      .eq (slice_eq)
   );

   // Flipping both sign bits maps two's-complement order onto unsigned order.
   assign sign_mask = {i_signed, {(WIDTH-1){1'b0}}};

   assign cur_less  = prev_less | (prev_equal & slice_lt);
   assign cur_equal = prev_equal & slice_eq;
   assign finish    = (idx == LAST_IDX) || ((EARLY_EXIT != 0) && !slice_eq);

   // Handshake: a request transfers on any rising edge where i_valid && o_ready;
   // o_ready is high only in IDLE, and o_valid is a single-cycle strobe in DONE
   // with no back-pressure from the consumer.
   always_comb begin
      state_nxt = state;
      o_ready   = 1'b0;
      o_valid   = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) state_nxt = BUSY;
         end
         BUSY: begin
            if (finish) state_nxt = DONE;
         end
         DONE: begin
            o_valid   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign o_state = state;

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_q        <= '0;
         b_q        <= '0;
         idx        <= '0;
         prev_less  <= 1'b0;
         prev_equal <= 1'b0;
         o_less     <= 1'b0;
         o_equal    <= 1'b0;
         o_greater  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_q        <= i_a ^ sign_mask;
                  b_q        <= i_b ^ sign_mask;
                  idx        <= '0;
                  prev_less  <= 1'b0;
                  prev_equal <= 1'b1;
               end
            end
            BUSY: begin
               a_q        <= a_q << DIGIT;
               b_q        <= b_q << DIGIT;
               idx        <= idx + IDX_W'(1);
               prev_less  <= cur_less;
               prev_equal <= cur_equal;
               if (finish) begin
                  o_less    <= cur_less;
                  o_equal   <= cur_equal;
                  o_greater <= ~cur_less & ~cur_equal;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
